// File: rtl/ext_mem_responder.sv
// Slave for an external burst bus: decodes a header word and streams LEN0/LEN1 words
// between the controller and a synchronous SRAM. Read data arrives two edges after issue.
module ext_mem_responder #(
    parameter int LEN0       = 64,
    parameter int LEN1       = 128,
    parameter int MEM_ADDR_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  IN_EXT_en,
    input  logic                  IN_EXT_oen,
    input  logic [31:0]           IN_EXT_bus,
    output logic [31:0]           OUT_EXT_bus,
    output logic                  OUT_MEM_ce,
    output logic                  OUT_MEM_we,
    output logic [MEM_ADDR_W-1:0] OUT_MEM_addr,
    output logic [31:0]           OUT_MEM_data,
    input  logic [31:0]           IN_MEM_data,
    output logic                  OUT_busy,
    output logic                  OUT_err
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HDR   = 3'd1;
    localparam logic [2:0] S_WDATA = 3'd2;
    localparam logic [2:0] S_RDATA = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int LMAX = (LEN0 > LEN1) ? LEN0 : LEN1;
    localparam int CW   = $clog2(LMAX + 1);
    localparam logic [CW-1:0] LAST0 = CW'(LEN0 - 1);
    localparam logic [CW-1:0] LAST1 = CW'(LEN1 - 1);

    logic [2:0]            state_q, state_d;
    logic                  wr_q, wr_d, lsel_q, lsel_d;
    logic [MEM_ADDR_W-1:0] base_q, base_d;
    logic [CW-1:0]         cnt_q, cnt_d, iss_q, iss_d;
    logic                  chk_q, chk_d;
    logic [31:0]           bus_q, bus_d, mdata_q, mdata_d;
    logic [MEM_ADDR_W-1:0] maddr_q, maddr_d;
    logic                  ce_q, ce_d, we_q, we_d, busy_q, busy_d, err_q, err_d;
    logic [CW-1:0]         last;

    assign last = lsel_q ? LAST1 : LAST0;

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        lsel_d  = lsel_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        iss_d   = iss_q;
        chk_d   = 1'b0;
        bus_d   = 32'd0;
        ce_d    = 1'b1;
        we_d    = 1'b1;
        maddr_d = maddr_q;
        mdata_d = mdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (IN_EXT_en) begin
                    state_d = S_HDR;
                    wr_d    = IN_EXT_bus[31];
                    lsel_d  = IN_EXT_bus[30];
                    base_d  = IN_EXT_bus[MEM_ADDR_W-1:0];
                    cnt_d   = '0;
                    iss_d   = '0;
                end
            end
            S_HDR, S_RDATA: begin
                if (!IN_EXT_en) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    // Reads are issued from the first header edge so each word lands in time.
                    if (!wr_q && iss_q <= last) begin
                        ce_d    = 1'b0;
                        maddr_d = base_q + MEM_ADDR_W'(iss_q);
                        iss_d   = iss_q + 1'b1;
                    end
                    if (state_q == S_HDR) begin
                        if (cnt_q != '0) begin
                            cnt_d   = '0;
                            state_d = wr_q ? S_WDATA : S_RDATA;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        bus_d = IN_MEM_data;
                        if (cnt_q != '0 && IN_EXT_oen)
                            err_d = 1'b1;
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == last) begin
                            state_d = S_DONE;
                            chk_d   = 1'b1;
                        end
                    end
                end
            end
            S_WDATA: begin
                if (!IN_EXT_en) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    ce_d    = 1'b0;
                    we_d    = 1'b0;
                    maddr_d = base_q + MEM_ADDR_W'(cnt_q);
                    mdata_d = IN_EXT_bus;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == last)
                        state_d = S_DONE;
                end
            end
            S_DONE: begin
                // The controller must still be listening on the edge after the last word.
                if (chk_q && IN_EXT_oen)
                    err_d = 1'b1;
                if (!IN_EXT_en)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            wr_q    <= 1'b0;
            lsel_q  <= 1'b0;
            base_q  <= '0;
            cnt_q   <= '0;
            iss_q   <= '0;
            chk_q   <= 1'b0;
            bus_q   <= 32'd0;
            mdata_q <= 32'd0;
            maddr_q <= '0;
            ce_q    <= 1'b1;
            we_q    <= 1'b1;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            lsel_q  <= lsel_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            iss_q   <= iss_d;
            chk_q   <= chk_d;
            bus_q   <= bus_d;
            mdata_q <= mdata_d;
            maddr_q <= maddr_d;
            ce_q    <= ce_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign OUT_EXT_bus  = bus_q;
    assign OUT_MEM_ce   = ce_q;
    assign OUT_MEM_we   = we_q;
    assign OUT_MEM_addr = maddr_q;
    assign OUT_MEM_data = mdata_q;
    assign OUT_busy     = busy_q;
    assign OUT_err      = err_q;
endmodule

// File: tb/tb_ext_mem_responder.sv
// Bench for ext_mem_responder: table of burst scenarios, hand-written reset sequence and
// random bursts, all checked edge by edge against a transaction-level reference model.
module tb_ext_mem_responder;
    localparam int LEN0 = 64;
    localparam int LEN1 = 128;
    localparam int AW   = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0, oen = 1'b1;
    logic [31:0]   bus = 32'd0;
    logic [31:0]   ext_out, mem_wdata, mem_rd;
    logic          ce, we, busy, err;
    logic [AW-1:0] maddr;

    int n_chk = 0, n_err = 0;
    int wr_seen = 0, rd_seen = 0;
    bit m_err = 1'b0;
    logic [31:0] mem     [0:(1<<AW)-1];
    bit          written [0:(1<<AW)-1];
    logic [31:0] ref_mem [0:(1<<AW)-1];

    ext_mem_responder #(.LEN0(LEN0), .LEN1(LEN1), .MEM_ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .IN_EXT_en(en), .IN_EXT_oen(oen), .IN_EXT_bus(bus),
        .OUT_EXT_bus(ext_out), .OUT_MEM_ce(ce), .OUT_MEM_we(we), .OUT_MEM_addr(maddr),
        .OUT_MEM_data(mem_wdata), .IN_MEM_data(mem_rd), .OUT_busy(busy), .OUT_err(err)
    );

    always #5 clk = ~clk;

    // Synchronous SRAM: samples the access on the edge after it is presented; unwritten words read as their address.
    always @(posedge clk) begin
        if (!ce && we)
            mem_rd <= written[maddr] ? mem[maddr] : 32'(maddr);
        if (!ce && !we) begin
            mem[maddr]     <= mem_wdata;
            written[maddr] <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!ce && !we) wr_seen++;
        if (!ce && we)  rd_seen++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, " bus"},  ext_out, 32'd0);
        chk({tag, " ce"},   32'(ce), 32'd1);
        chk({tag, " we"},   32'(we), 32'd1);
        chk({tag, " addr"}, 32'(maddr), 32'd0);
        chk({tag, " data"}, mem_wdata, 32'd0);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " err"},  32'(err), 32'd0);
    endtask

    task automatic do_reset();
        en = 1'b0; oen = 1'b1; bus = 32'd0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_idle("reset");
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        m_err = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // One burst: en drops at edge endE (abort edge, or after x extra DONE edges).
    task automatic run_txn(input bit wr, input bit lsel, input logic [29:0] base, input int ab,
                           input int oe, input int x, input bit dpat, input int exp_nwr,
                           input bit exp_err, input string tag);
        int len, endE, w0, r0;
        logic [AW-1:0] a;
        logic [31:0] d, eb;
        bit wnow;
        len  = lsel ? LEN1 : LEN0;
        endE = (ab >= 0) ? ab : 3 + len + x;
        w0 = wr_seen;
        r0 = rd_seen;
        for (int e = 0; e <= endE; e++) begin
            en   = (e != endE);
            oen  = wr ? 1'b1 : (e == oe);
            a    = AW'(base) + AW'(e - 3);
            wnow = wr && e >= 3 && e < 3 + len && e < endE;
            if (e == 0)
                bus = {wr, lsel, base};
            else if (wr && e >= 3 && e < 3 + len)
                bus = dpat ? 32'hA000_0000 + 32'(e - 3) : $urandom;
            else if (e >= 3 + len)
                bus = {1'b0, 1'b1, 30'h3};
            else
                bus = $urandom;
            d = bus;
            @(posedge clk);
            #1;
            if (ab >= 0 && e == ab) m_err = 1'b1;
            if (!wr && e == oe && e >= 4 && e <= 3 + len) m_err = 1'b1;
            if (wnow) ref_mem[a] = d;
            eb = (!wr && e >= 3 && e < 3 + len && e < endE) ? ref_mem[a] : 32'd0;
            chk($sformatf("%s e%0d bus", tag, e), ext_out, eb);
            chk($sformatf("%s e%0d busy", tag, e), 32'(busy), 32'(e < endE));
            chk($sformatf("%s e%0d err", tag, e), 32'(err), 32'(m_err));
            chk($sformatf("%s e%0d we", tag, e), 32'(we), 32'(!wnow));
            if (wnow) begin
                chk($sformatf("%s e%0d waddr", tag, e), 32'(maddr), 32'(a));
                chk($sformatf("%s e%0d wdata", tag, e), mem_wdata, d);
            end
            if (e >= 3 + len || e >= endE)
                chk($sformatf("%s e%0d ce", tag, e), 32'(ce), 32'd1);
        end
        chk({tag, " nwrites"}, 32'(wr_seen - w0), 32'(exp_nwr));
        if (ab < 0)
            chk({tag, " nreads"}, 32'(rd_seen - r0), wr ? 32'd0 : 32'(len));
        chk({tag, " final err"}, 32'(err), 32'(exp_err));
    endtask

    typedef struct {
        bit          do_rst;
        bit          wr;
        bit          lsel;
        logic [29:0] base;
        int          ab;
        int          oe;
        int          x;
        bit          dpat;
        int          nwr;
        bit          err;
    } vec_t;

    vec_t tbl [13];

    initial begin
        int r0, w0;
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = 32'(i);

        tbl[0]  = '{1'b1, 1'b0, 1'b1, 30'h0000FFF0, -1, -1, 0, 1'b0, 0,   1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 30'h00000010, -1, -1, 0, 1'b1, 64,  1'b0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 30'h00000100,  9, -1, 0, 1'b0, 6,   1'b1};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 30'h00000020, -1, -1, 0, 1'b0, 0,   1'b1};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 30'h00000005, -1,  4, 0, 1'b0, 0,   1'b1};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 30'h00000030, -1,  3, 0, 1'b0, 0,   1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 30'h00000031, -1, 67, 0, 1'b0, 0,   1'b1};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 30'h0000FFC0, -1, -1, 4, 1'b0, 128, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 30'h00000040, -1, -1, 0, 1'b0, 0,   1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 30'h00000050,  2, -1, 0, 1'b0, 0,   1'b1};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 30'h00000060, 20, -1, 0, 1'b0, 0,   1'b1};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 30'h00000070,  3, -1, 0, 1'b0, 0,   1'b1};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 30'h3FFF0010, -1, -1, 1, 1'b0, 0,   1'b0};

        for (int i = 0; i < 13; i++) begin
            if (tbl[i].do_rst) do_reset();
            run_txn(tbl[i].wr, tbl[i].lsel, tbl[i].base, tbl[i].ab, tbl[i].oe, tbl[i].x,
                    tbl[i].dpat, tbl[i].nwr, tbl[i].err, $sformatf("vec%0d", i));
        end

        // Asynchronous reset just before edge 10 of a read.
        do_reset();
        en = 1'b1; oen = 1'b0; bus = {2'b00, 30'h200};
        for (int e = 0; e < 10; e++) begin
            @(posedge clk);
            #1 bus = $urandom;
        end
        #2 rst = 1'b1;
        en = 1'b0;
        #1 check_idle("midrst");
        r0 = rd_seen;
        w0 = wr_seen;
        @(posedge clk);
        #2 rst = 1'b0;
        m_err = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("midrst reads after", 32'(rd_seen - r0), 32'd0);
        chk("midrst writes after", 32'(wr_seen - w0), 32'd0);
        chk("midrst busy after", 32'(busy), 32'd0);
        run_txn(1'b0, 1'b0, 30'h200, -1, -1, 0, 1'b0, 0, 1'b0, "after_rst");

        for (int i = 0; i < 6; i++) begin
            bit wr, ls, xerr;
            logic [29:0] b;
            int len, ab, oe, x, nwr;
            wr  = 1'($urandom_range(0, 1));
            ls  = 1'($urandom_range(0, 1));
            b   = 30'($urandom);
            len = ls ? LEN1 : LEN0;
            ab  = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(1, 2 + len));
            oe  = (!wr && ab < 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(3, 3 + len)) : -1;
            x   = int'($urandom_range(0, 3));
            nwr = !wr ? 0 : (ab < 0 ? len : (ab > 3 ? ab - 3 : 0));
            xerr = (ab >= 0) || (oe >= 4);
            do_reset();
            run_txn(wr, ls, b, ab, oe, x, 1'b0, nwr, xerr, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
